uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//   Serial-to-byte UART receiver: 8N1 (optional parity), LSB first. Sits directly upstream
//   of the RX buffer stage and drives its uart_rx_data / uart_rx_data_ready inputs.
//   Recovers each byte by sampling mid-bit from a clk-based bit-period counter.
//   Rejects start-bit glitches and flags framing errors.
// PARAMETERS
//   BAUD_DIV    434  clk cycles per bit (50 MHz / 115200); legal range 4..65535
//   PARITY_ODD  0    parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
//   clk                 in   1  system clock; all logic on posedge
//   rst_n               in   1  asynchronous, active-low reset
//   uart_rxd            in   1  raw serial line (asynchronous, idle high)
//   uart_rx_data        out  8  last good byte; held until the next good byte
//   uart_rx_data_ready  out  1  1-clk pulse: uart_rx_data newly valid
//   uart_rx_frame_err   out  1  1-clk pulse: stop bit sampled low; byte discarded
//   uart_rx_busy        out  1  high from validated start bit through the stop-bit sample
// BEHAVIOUR
//   - Reset: all outputs 0. 2-FF synchronizer resets to 1. FSM = IDLE, armed = 0.
//     Bit counter and shift register reset to 0.
//   - uart_rxd passes through the 2-FF synchronizer (rxd_s). All decisions use rxd_s only.
//   - armed: set after rxd_s is high for BAUD_DIV consecutive clks. Cleared on reset and on
//     frame error. A falling edge seen while not armed is ignored, so a line held low at
//     reset release or during a break never produces a byte.
//   - Bit counter width: $clog2(BAUD_DIV). Counts 0..BAUD_DIV-1 and wraps to 0.
//   - FSM states:
//     IDLE: on armed & rxd_s 1->0 -> START, counter = 0.
//     START: at count (BAUD_DIV/2)-1, sample rxd_s.
//       0 -> DATA, counter = 0, busy = 1.
//       1 -> IDLE (glitch): no pulses, armed stays set.
//     DATA: each time the counter hits BAUD_DIV-1, shift rxd_s into bit[n] (LSB first).
//       After bit 7 -> PARITY if the macro is defined, else STOP.
//     PARITY: sample after one further bit period, then -> STOP.
//     STOP: sample at BAUD_DIV-1.
//       1 -> next clk: data_ready = 1, uart_rx_data updated.
//       0 -> next clk: frame_err = 1, data unchanged, armed = 0.
//       Either way -> IDLE, busy = 0.
//   - Latency: data_ready rises 2 + (BAUD_DIV/2) + 9*BAUD_DIV clks after the uart_rxd
//     falling edge (one extra BAUD_DIV with parity). Tolerance: +/-1 clk.
//   - data_ready and frame_err are never high together. Neither is high for more than 1 clk.
//   - No back-pressure: the downstream stage must accept every data_ready pulse.
//   - Reset mid-frame: immediate abort, no pulse. The receiver waits for a re-arm.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Adds the PARITY state and output port uart_rx_parity_err (out, 1, 1-clk pulse).
//     - Parity mismatch with a good stop bit: parity_err pulses in place of data_ready,
//       byte discarded, armed stays set.
//     - Frame error takes precedence over parity error.
//   UART_RX_PARITY_EN undefined:
//     - 10-bit frame. No parity port or logic exists.
// TESTING (sim with BAUD_DIV = 8)
//   - Send 0xA5, 8N1, idle high between frames -> one data_ready pulse, uart_rx_data = 0xA5,
//     busy low after the stop sample.
//   - Send 0x00 then 0xFF back-to-back, no idle gap -> two pulses, data 0x00 then 0xFF,
//     no frame_err.
//   - 2-clk low glitch on an idle line -> FSM returns to IDLE, no data_ready, no frame_err.
//   - 0x3C with stop bit forced low -> frame_err pulse, uart_rx_data keeps its previous
//     value, no new byte until the line is high 8 clks.
//   - uart_rxd low at reset release, then a valid 0x55 after 8+ high clks -> exactly one
//     pulse, data = 0x55.
//   - With UART_RX_PARITY_EN, PARITY_ODD = 0: send 0x07 with parity bit 0 -> parity_err
//     pulse, no data_ready. Send 0x07 with parity bit 1 -> data_ready, data = 0x07.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: received-byte bundle between the UART receiver and the RX buffer stage.
// The parity error strobe exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_byte_if;
    logic [7:0] uart_rx_data;
    logic       uart_rx_data_ready;
    logic       uart_rx_frame_err;
    logic       uart_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       uart_rx_parity_err;

    modport master (
        output uart_rx_data,
        output uart_rx_data_ready,
        output uart_rx_frame_err,
        output uart_rx_busy,
        output uart_rx_parity_err
    );

    modport slave (
        input  uart_rx_data,
        input  uart_rx_data_ready,
        input  uart_rx_frame_err,
        input  uart_rx_busy,
        input  uart_rx_parity_err
    );
`else
    modport master (
        output uart_rx_data,
        output uart_rx_data_ready,
        output uart_rx_frame_err,
        output uart_rx_busy
    );

    modport slave (
        input  uart_rx_data,
        input  uart_rx_data_ready,
        input  uart_rx_frame_err,
        input  uart_rx_busy
    );
`endif
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: serial-to-byte UART receiver, 8 data bits LSB first, one stop bit.
// Each bit is sampled mid-period using a clk-based counter of BAUD_DIV cycles.
// A start bit is only accepted once the line has idled high for BAUD_DIV clks (armed),
// and a start bit that is high again at its midpoint is treated as a glitch.
// Optional parity bit: define UART_RX_PARITY_EN (adds PARITY state and uart_rx_parity_err).
module uart_rx_byte #(
    parameter int BAUD_DIV   = 434,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rxd,
    uart_rx_byte_if.master rx
);
    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Synchronizer and edge-detect history; idle-high reset so release never looks like an edge
    logic sync1_reg;
    logic rxd_s_reg;
    logic rxd_prev_reg;

    state_t        state_reg,   state_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          armed_reg,   armed_next;
    logic [CW-1:0] arm_cnt_reg, arm_cnt_next;
    logic [7:0]    data_reg,    data_next;
    logic          ready_reg,   ready_next;
    logic          ferr_reg,    ferr_next;
    logic          cnt_wrap;

`ifdef UART_RX_PARITY_EN
    logic          par_bit_reg, par_bit_next;
    logic          perr_reg,    perr_next;
    logic          parity_bad;

    // Received data plus parity bit must have the configured number-of-ones sense
    assign parity_bad = ((^shift_reg) ^ par_bit_reg) != PARITY_ODD;
`else
    // Parity sense has no meaning without the parity bit
    logic unused_cfg;
    assign unused_cfg = PARITY_ODD;
`endif

    assign cnt_wrap = (cnt_reg == CNT_LAST);

    // Two-stage synchronizer for the asynchronous serial line, plus one history stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b1;
            rxd_s_reg    <= 1'b1;
            rxd_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= uart_rxd;
            rxd_s_reg    <= sync1_reg;
            rxd_prev_reg <= rxd_s_reg;
        end
    end

    // Receiver state, counters and output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            armed_reg   <= 1'b0;
            arm_cnt_reg <= '0;
            data_reg    <= '0;
            ready_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            armed_reg   <= armed_next;
            arm_cnt_reg <= arm_cnt_next;
            data_reg    <= data_next;
            ready_reg   <= ready_next;
            ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= par_bit_next;
            perr_reg    <= perr_next;
`endif
        end
    end

    // Arm tracking, next-state and strobe generation
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        armed_next   = armed_reg;
        arm_cnt_next = arm_cnt_reg;
        data_next    = data_reg;
        ready_next   = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit_reg;
        perr_next    = 1'b0;
`endif

        // Line must stay high for BAUD_DIV consecutive clks before any start bit counts
        if (!armed_reg) begin
            if (!rxd_s_reg) begin
                arm_cnt_next = '0;
            end else if (arm_cnt_reg == CNT_LAST) begin
                armed_next = 1'b1;
            end else begin
                arm_cnt_next = arm_cnt_reg + CNT_ONE;
            end
        end

        case (state_reg)
            IDLE: begin
                if (armed_reg && rxd_prev_reg && !rxd_s_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rxd_s_reg) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_wrap) begin
                    cnt_next     = '0;
                    shift_next   = {rxd_s_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_wrap) begin
                    cnt_next     = '0;
                    par_bit_next = rxd_s_reg;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (cnt_wrap) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxd_s_reg) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_bad) begin
                            perr_next = 1'b1;
                        end else begin
                            ready_next = 1'b1;
                            data_next  = shift_reg;
                        end
`else
                        ready_next = 1'b1;
                        data_next  = shift_reg;
`endif
                    end else begin
                        // Low stop bit may be a break: require a fresh idle period
                        ferr_next    = 1'b1;
                        armed_next   = 1'b0;
                        arm_cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx.uart_rx_data       = data_reg;
    assign rx.uart_rx_data_ready = ready_reg;
    assign rx.uart_rx_frame_err  = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign rx.uart_rx_parity_err = perr_reg;
    assign rx.uart_rx_busy       = (state_reg == DATA) || (state_reg == PARITY) ||
                                   (state_reg == STOP);
`else
    assign rx.uart_rx_busy       = (state_reg == DATA) || (state_reg == STOP);
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: bench for uart_rx_byte with BAUD_DIV = 8.
// Table of directed frames, hand-written corner sequences, then random frames
// checked against a frame-level reference model.
module tb_uart_rx_byte;
    localparam int BD  = 8;
    localparam bit ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int EXP_LAT = 2 + BD / 2 + (NBITS - 1) * BD;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic uart_rxd = 1'b0;

    uart_rx_byte_if rx_if ();

    uart_rx_byte #(.BAUD_DIV(BD), .PARITY_ODD(ODD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .rx       (rx_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int n_ready = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
    int s_ready = 0, s_ferr = 0, s_perr = 0, s_busy = 0;
    logic [7:0] model_data;
    logic prev_ready = 1'b0, prev_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts strobes, checks exclusivity, width and latency
    always @(negedge clk) begin
        logic perr_now;
        int   lat;
`ifdef UART_RX_PARITY_EN
        perr_now = rx_if.uart_rx_parity_err;
`else
        perr_now = 1'b0;
`endif
        if (rst_n) begin
            if (rx_if.uart_rx_busy) n_busy++;
            if (rx_if.uart_rx_data_ready || rx_if.uart_rx_frame_err || perr_now) begin
                check("strobe_exclusive",
                      32'(rx_if.uart_rx_data_ready) + 32'(rx_if.uart_rx_frame_err) + 32'(perr_now),
                      32'd1);
            end
            if (rx_if.uart_rx_data_ready) begin
                n_ready++;
                check("ready_width", 32'(prev_ready), 32'd0);
                lat = cyc - start_cyc;
                total++;
                if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
                    bad++;
                    $display("FAIL latency: got %0d clks want %0d..%0d", lat, EXP_LAT - 1, EXP_LAT + 1);
                end
            end
            if (rx_if.uart_rx_frame_err) begin
                n_ferr++;
                check("ferr_width", 32'(prev_ferr), 32'd0);
            end
            if (perr_now) n_perr++;
        end
        prev_ready = rx_if.uart_rx_data_ready;
        prev_ferr  = rx_if.uart_rx_frame_err;
    end

    // All stimulus tasks start and end #1 after a rising edge
    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit,
                              input int busy_exp);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (PAR_EN) begin
            bits[9]  = par;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end
        for (int i = 0; i < NBITS; i++) begin
            uart_rxd = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (BD) @(posedge clk);
            #1;
            if (i == 5) check("busy_mid_frame", 32'(rx_if.uart_rx_busy), 32'(busy_exp));
        end
    endtask

    task automatic snap();
        s_ready = n_ready;
        s_ferr  = n_ferr;
        s_perr  = n_perr;
        s_busy  = n_busy;
    endtask

    task automatic expect_frame(input string name, input int e_rdy, input int e_ferr,
                                input int e_perr, input logic [7:0] e_data);
        check({name, "_ready"}, 32'(n_ready - s_ready), 32'(e_rdy));
        check({name, "_ferr"}, 32'(n_ferr - s_ferr), 32'(e_ferr));
        if (PAR_EN) check({name, "_perr"}, 32'(n_perr - s_perr), 32'(e_perr));
        check({name, "_data"}, 32'(rx_if.uart_rx_data), 32'(e_data));
        check({name, "_busy_after"}, 32'(rx_if.uart_rx_busy), 32'd0);
        $display("frame %s: ready=%0d ferr=%0d perr=%0d data=%02h", name,
                 n_ready - s_ready, n_ferr - s_ferr, n_perr - s_perr, rx_if.uart_rx_data);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return logic'(($countones(d) + (ODD ? 1 : 0)) % 2);
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       flip;
        int         gap;
        int         e_rdy;
        int         e_ferr;
        logic [7:0] e_data;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [7:0] d;
        logic       stop_b, flip, p;
        int         e_rdy, e_ferr, e_perr, gap;

        vt[0] = '{8'hA5, 1'b1, 1'b0, 12, 1, 0, 8'hA5};
        vt[1] = '{8'h00, 1'b1, 1'b0, 0,  1, 0, 8'h00};
        vt[2] = '{8'hFF, 1'b1, 1'b0, 12, 1, 0, 8'hFF};
        vt[3] = '{8'h3C, 1'b0, 1'b0, 12, 0, 1, 8'hFF};
        vt[4] = '{8'h81, 1'b1, 1'b0, 12, 1, 0, 8'h81};

        // Reset state, with the line held low through reset release
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(rx_if.uart_rx_data), 32'd0);
        check("rst_ready", 32'(rx_if.uart_rx_data_ready), 32'd0);
        check("rst_ferr", 32'(rx_if.uart_rx_frame_err), 32'd0);
        check("rst_busy", 32'(rx_if.uart_rx_busy), 32'd0);
        rst_n = 1'b1;
        snap();
        repeat (20) @(posedge clk);
        #1;
        idle(12);
        send_frame(8'h55, good_par(8'h55), 1'b1, 1);
        idle(12);
        expect_frame("low_at_reset", 1, 0, 0, 8'h55);
        check("low_at_reset_busy_total", 32'(n_busy - s_busy > 0), 32'd1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            snap();
            send_frame(vt[i].data, good_par(vt[i].data) ^ vt[i].flip, vt[i].stop_bit, 1);
            idle(vt[i].gap);
            expect_frame($sformatf("table%0d", i), vt[i].e_rdy, vt[i].e_ferr, 0, vt[i].e_data);
        end
        model_data = 8'h81;

        // Short low glitch on an idle armed line
        snap();
        uart_rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        expect_frame("glitch", 0, 0, 0, model_data);
        check("glitch_busy", 32'(n_busy - s_busy), 32'd0);

        // After a frame error, a frame arriving before a full idle period is ignored
        snap();
        send_frame(8'h3C, good_par(8'h3C), 1'b0, 1);
        idle(3);
        send_frame(8'h00, good_par(8'h00), 1'b1, 0);
        idle(12);
        expect_frame("unarmed", 0, 1, 0, model_data);
        snap();
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 1);
        idle(4);
        expect_frame("rearmed", 1, 0, 0, 8'h5A);
        model_data = 8'h5A;

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 1);
        idle(4);
        expect_frame("par_bad", 0, 0, 1, 8'h5A);
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1);
        idle(4);
        expect_frame("par_good", 1, 0, 0, 8'h07);
        snap();
        send_frame(8'h07, 1'b0, 1'b0, 1);
        idle(12);
        expect_frame("par_and_frame", 0, 1, 0, 8'h07);
        model_data = 8'h07;
`endif

        // Random frames against the frame-level model
        for (int k = 0; k < 24; k++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 5) != 0);
            flip   = PAR_EN && ($urandom_range(0, 3) == 0);
            p      = good_par(d) ^ flip;
            e_rdy = 0; e_ferr = 0; e_perr = 0;
            if (!stop_b) begin
                e_ferr = 1;
            end else if (PAR_EN && ((($countones(d) + (p ? 1 : 0)) % 2) != (ODD ? 1 : 0))) begin
                e_perr = 1;
            end else begin
                e_rdy      = 1;
                model_data = d;
            end
            gap = stop_b ? int'($urandom_range(0, 6)) : BD + 4 + int'($urandom_range(0, 6));
            snap();
            send_frame(d, p, stop_b, 1);
            idle(gap);
            expect_frame($sformatf("rand%0d_%02h", k, d), e_rdy, e_ferr, e_perr, model_data);
        end

        // Reset in the middle of a frame aborts it without a pulse
        snap();
        uart_rxd = 1'b0;
        start_cyc = cyc;
        repeat (BD) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (3 * BD) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(rx_if.uart_rx_busy), 32'd0);
        check("midrst_data", 32'(rx_if.uart_rx_data), 32'd0);
        check("midrst_ready_cnt", 32'(n_ready - s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        snap();
        send_frame(8'h3E, good_par(8'h3E), 1'b1, 1);
        idle(4);
        expect_frame("after_midrst", 1, 0, 0, 8'h3E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
